adc_chan_sequencer: RTL

ADC_CHAN_SEQUENCER -- requirements
Module: adc_chan_sequencer

---
 rtl/adc_seq_pkg.sv | 14 +
 rtl/adc_seq_edge_det.sv | 22 ++
 rtl/adc_chan_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC channel sequencer.
package adc_seq_pkg;

    localparam int unsigned NUM_CH_DEFAULT = 4;
    localparam int unsigned SAMPLE_W       = 24;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StConvert,
        StRead
    } seq_state_e;

endpackage

// File: rtl/adc_seq_edge_det.sv
// Registered rising-edge detector: flags a 0->1 change against last cycle's value.
module adc_seq_edge_det (
    input  logic adc_clk,
    input  logic nRST,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // Keep the previous sample of the input.
    always_ff @(posedge adc_clk or negedge nRST) begin
        if (!nRST) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/adc_chan_sequencer.sv
// ADC channel sequencer: steps the input mux over the enabled channels once per
// sync edge, handshaking START/DRDY with the ADC and the serial reader.
// Optional feature: define ADC_SEQ_TIMEOUT_EN to abort a conversion after
// DRDY_TIMEOUT cycles without a drdy edge (sets timeout_err_o).
module adc_chan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH       = NUM_CH_DEFAULT,
    parameter int unsigned DRDY_TIMEOUT = 1023,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                adc_clk,
    input  logic                nRST,
    input  logic                sync_i,
    input  logic [NUM_CH-1:0]   chan_en_i,
    input  logic [7:0]          settle_cycles_i,
    input  logic                drdy_i,
    input  logic                rd_done_i,
    input  logic [SAMPLE_W-1:0] rd_data_i,
    input  logic                err_clr_i,
    output logic [CH_W-1:0]     a_mux_o,
    output logic                start_o,
    output logic                rd_req_o,
    output logic                out_valid_o,
    output logic [CH_W-1:0]     out_chan_o,
    output logic [SAMPLE_W-1:0] out_data_o,
    output logic                busy_o,
    output logic                overrun_err_o,
    output logic                timeout_err_o
);

    if (DRDY_TIMEOUT == 0) begin : g_bad_timeout
        $error("DRDY_TIMEOUT must be nonzero");
    end

    seq_state_e          state_q;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     mux_q;
    logic [7:0]          cnt_q;
    logic                start_q;
    logic                rd_req_q;
    logic                out_valid_q;
    logic [CH_W-1:0]     out_chan_q;
    logic [SAMPLE_W-1:0] out_data_q;
    logic                overrun_q;
    logic                sync_rise;
    logic                drdy_rise;

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(DRDY_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             timeout_q;
`endif

    // True if any channel at index >= from is enabled in m.
    function automatic logic has_en_from(input logic [NUM_CH-1:0] m, input int from);
        has_en_from = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (i >= from && m[i]) has_en_from = 1'b1;
        end
    endfunction

    // Lowest enabled index >= from (0 if none).
    function automatic logic [CH_W-1:0] first_en_from(input logic [NUM_CH-1:0] m, input int from);
        first_en_from = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (i >= from && m[i]) first_en_from = CH_W'(i);
        end
    endfunction

    adc_seq_edge_det u_sync_edge (
        .adc_clk (adc_clk),
        .nRST    (nRST),
        .sig_i   (sync_i),
        .rise_o  (sync_rise)
    );

    adc_seq_edge_det u_drdy_edge (
        .adc_clk (adc_clk),
        .nRST    (nRST),
        .sig_i   (drdy_i),
        .rise_o  (drdy_rise)
    );

    // Sequencer FSM with registered outputs and sticky error flags.
    always_ff @(posedge adc_clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            mux_q       <= '0;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            rd_req_q    <= 1'b0;
            out_valid_q <= 1'b0;
            // Clear first so a same-cycle set event below wins.
            if (err_clr_i) begin
                overrun_q <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
                timeout_q <= 1'b0;
`endif
            end
            if (sync_rise) begin
                if (state_q != StIdle) begin
                    overrun_q <= 1'b1;
                    start_q   <= 1'b0;
                    // A sample completing this cycle is still delivered.
                    if (state_q == StRead && rd_done_i) begin
                        out_valid_q <= 1'b1;
                        out_chan_q  <= mux_q;
                        out_data_q  <= rd_data_i;
                    end
                end
                if (chan_en_i != '0) begin
                    mask_q  <= chan_en_i;
                    mux_q   <= first_en_from(chan_en_i, 0);
                    cnt_q   <= settle_cycles_i;
                    state_q <= StSettle;
                end else begin
                    state_q <= StIdle;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        start_q <= 1'b0;
                    end
                    StSettle: begin
                        if (cnt_q == 8'd0) begin
                            start_q <= 1'b1;
                            state_q <= StConvert;
`ifdef ADC_SEQ_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                    StConvert: begin
                        if (drdy_rise) begin
                            start_q  <= 1'b0;
                            rd_req_q <= 1'b1;
                            state_q  <= StRead;
`ifdef ADC_SEQ_TIMEOUT_EN
                        end else if (tmo_q == TMO_W'(DRDY_TIMEOUT - 1)) begin
                            start_q   <= 1'b0;
                            timeout_q <= 1'b1;
                            state_q   <= StIdle;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
`endif
                        end
                    end
                    StRead: begin
                        if (rd_done_i) begin
                            out_valid_q <= 1'b1;
                            out_chan_q  <= mux_q;
                            out_data_q  <= rd_data_i;
                            if (has_en_from(mask_q, int'(mux_q) + 1)) begin
                                mux_q   <= first_en_from(mask_q, int'(mux_q) + 1);
                                cnt_q   <= settle_cycles_i;
                                state_q <= StSettle;
                            end else begin
                                state_q <= StIdle;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign a_mux_o       = mux_q;
    assign start_o       = start_q;
    assign rd_req_o      = rd_req_q;
    assign out_valid_o   = out_valid_q;
    assign out_chan_o    = out_chan_q;
    assign out_data_o    = out_data_q;
    assign busy_o        = (state_q != StIdle);
    assign overrun_err_o = overrun_q;
`ifdef ADC_SEQ_TIMEOUT_EN
    assign timeout_err_o = timeout_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule
